// File: rtl/hack_uart_pkg.sv
// Shared types and constants for the Hack UART blocks.
// The parity-extended frame is selected in hack_uart_rx with HACK_UART_RX_PARITY_EN.
package hack_uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int ST_NOT_EMPTY  = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_OVERRUN    = 2;
    localparam int ST_FRAME_ERR  = 3;
    localparam int ST_PARITY_ERR = 4;

    // Status word carries an 8-bit count; deeper FIFOs clamp at 255.
    function automatic logic [7:0] sat_count8(input logic [8:0] cnt);
        return (cnt > 9'd255) ? 8'hFF : cnt[7:0];
    endfunction

endpackage

// File: rtl/hack_uart_fifo.sv
// Synchronous first-word-fall-through byte FIFO; dout always shows the head entry.
// Shared by the receiver and the planned transmitter.
module hack_uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: storage is not reset; validity comes only from the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/hack_uart_rx.sv
// Memory-mapped UART receiver: 8N1 deserialiser feeding a FWFT FIFO read via inM.
// Define HACK_UART_RX_PARITY_EN for 8E1 frames with a sticky parity error flag.
module hack_uart_rx
    import hack_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx,
    input  logic        pop,
    input  logic        clr_err,
    output logic [15:0] rx_data,
    output logic [15:0] rx_status,
    output logic        rx_irq
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t             state;
    logic                  rx_meta;
    logic                  rx_sync;
    logic [CW-1:0]         clk_cnt;
    logic [2:0]            bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  sample_tick;
    logic                  stop_tick;
    logic                  push;
    logic                  frame_ev;
    logic                  overrun_ev;
    logic                  overrun;
    logic                  frame_err;
    logic [DATA_BITS-1:0]  fifo_dout;
    logic [FCW-1:0]        fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
`ifdef HACK_UART_RX_PARITY_EN
    logic                  par_bad;
    logic                  parity_ev;
    logic                  parity_err;
`endif

    // Synchroniser resets to the idle-line level so reset release does not fake a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep this a genuine two-stage shift.
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign sample_tick = (clk_cnt == BIT_END);
    assign stop_tick   = (state == STOP) && sample_tick;
    assign frame_ev    = stop_tick && !rx_sync;
`ifdef HACK_UART_RX_PARITY_EN
    assign push        = stop_tick && rx_sync && !par_bad;
    assign parity_ev   = stop_tick && par_bad;
`else
    assign push        = stop_tick && rx_sync;
`endif
    assign overrun_ev  = push && fifo_full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef HACK_UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
`ifdef HACK_UART_RX_PARITY_EN
                    par_bad <= 1'b0;
`endif
                    if (!rx_sync) state <= START;
                end
                START: begin
                    if (clk_cnt == HALF_END) begin
                        clk_cnt <= '0;
                        state   <= rx_sync ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef HACK_UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`ifdef HACK_UART_RX_PARITY_EN
                PARITY: begin
                    if (sample_tick) begin
                        clk_cnt <= '0;
                        par_bad <= ^{shreg, rx_sync};
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (sample_tick) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
`ifdef HACK_UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (overrun_ev)    overrun   <= 1'b1;
            else if (clr_err)  overrun   <= 1'b0;
            if (frame_ev)      frame_err <= 1'b1;
            else if (clr_err)  frame_err <= 1'b0;
`ifdef HACK_UART_RX_PARITY_EN
            if (parity_ev)     parity_err <= 1'b1;
            else if (clr_err)  parity_err <= 1'b0;
`endif
        end
    end

    hack_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (shreg),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rx_status                = '0;
        rx_status[ST_NOT_EMPTY]  = !fifo_empty;
        rx_status[ST_FULL]       = fifo_full;
        rx_status[ST_OVERRUN]    = overrun;
        rx_status[ST_FRAME_ERR]  = frame_err;
`ifdef HACK_UART_RX_PARITY_EN
        rx_status[ST_PARITY_ERR] = parity_err;
`endif
        rx_status[15:8]          = sat_count8(9'(fifo_count));
    end

    assign rx_data = {8'h00, (fifo_empty ? 8'h00 : fifo_dout)};
    assign rx_irq  = !fifo_empty;

endmodule
